// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan decoder: segment bit indices,
// FSM state encoding and the lit-segment pattern for each hex digit.
package seg7_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SETTLE   = 2'd1,
    ST_CAPTURED = 2'd2
  } seg7_state_e;

  // Active-high lit-segment sets {G,F,E,D,C,B,A}, entry n is hex digit n.
  localparam logic [15:0][6:0] SEG_PATTERNS = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational lookup from an active-low segment drive to a hex nibble;
// hit is low for any pattern that is not one of the sixteen hex glyphs.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg_n,
  output logic       hit,
  output logic [3:0] nibble
);

  logic [6:0] lit_s;

  // Match the lit segments against the glyph table.
  always_comb begin
    lit_s  = ~seg_n;
    hit    = 1'b1;
    nibble = 4'h0;
    case (lit_s)
      SEG_PATTERNS[0]:  nibble = 4'h0;
      SEG_PATTERNS[1]:  nibble = 4'h1;
      SEG_PATTERNS[2]:  nibble = 4'h2;
      SEG_PATTERNS[3]:  nibble = 4'h3;
      SEG_PATTERNS[4]:  nibble = 4'h4;
      SEG_PATTERNS[5]:  nibble = 4'h5;
      SEG_PATTERNS[6]:  nibble = 4'h6;
      SEG_PATTERNS[7]:  nibble = 4'h7;
      SEG_PATTERNS[8]:  nibble = 4'h8;
      SEG_PATTERNS[9]:  nibble = 4'h9;
      SEG_PATTERNS[10]: nibble = 4'hA;
      SEG_PATTERNS[11]: nibble = 4'hB;
      SEG_PATTERNS[12]: nibble = 4'hC;
      SEG_PATTERNS[13]: nibble = 4'hD;
      SEG_PATTERNS[14]: nibble = 4'hE;
      SEG_PATTERNS[15]: nibble = 4'hF;
      default: begin
        hit    = 1'b0;
        nibble = 4'h0;
      end
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers hex digits from a multiplexed 7-segment display drive by waiting
// for a stable anode/segment pair. Optional decimal point: SEG7_DP_EN.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 8,
  parameter int NDIG          = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [6:0]          seg_n,
  input  logic [NDIG-1:0]     an_n,
`ifdef SEG7_DP_EN
  input  logic                dp_n,
  output logic [NDIG-1:0]     dp,
`endif
  input  logic                clear,
  output logic [4*NDIG-1:0]   digits,
  output logic [NDIG-1:0]     digit_valid,
  output logic [NDIG-1:0]     pattern_err,
  output logic                update
);

  localparam int         IDXW    = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [7:0] CNT_CAP = 8'(STABLE_CYCLES - 1);
  localparam logic [7:0] CNT_SAT = 8'(STABLE_CYCLES);

  logic [6:0]        seg_r, lat_seg_r;
  logic [NDIG-1:0]   an_r;
  logic [IDXW-1:0]   idx_s, lat_idx_r;
  logic              dp_r, lat_dp_r;
  logic [7:0]        cnt_r;
  seg7_state_e       state_r, state_nx_s;
  logic              sel_s, same_s, match_s, load_s, capture_s;
  logic              hit_s;
  logic [3:0]        nibble_s;
  logic [4*NDIG-1:0] digits_r;
  logic [NDIG-1:0]   valid_r, perr_r, dp_out_r;
  logic              update_r;

  // Single input register stage; idle value is all-ones (nothing driven).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_r <= 7'h7F;
      an_r  <= {NDIG{1'b1}};
      dp_r  <= 1'b1;
    end else begin
      seg_r <= seg_n;
      an_r  <= an_n;
`ifdef SEG7_DP_EN
      dp_r  <= dp_n;
`else
      dp_r  <= 1'b1;
`endif
    end
  end

  // Selectable means exactly one anode low; OR-ing indices is exact then.
  always_comb begin
    idx_s = {IDXW{1'b0}};
    for (int i = 0; i < NDIG; i++) begin
      idx_s = idx_s | (an_r[i] ? {IDXW{1'b0}} : IDXW'(i));
    end
    sel_s   = ($countones(~an_r) == 32'd1);
    same_s  = (idx_s == lat_idx_r) && (seg_r == lat_seg_r) && (dp_r == lat_dp_r);
    match_s = sel_s && same_s;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next-state logic; clear always wins.
  always_comb begin
    state_nx_s = state_r;
    if (clear) begin
      state_nx_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:     state_nx_s = sel_s ? ST_SETTLE : ST_IDLE;
        ST_SETTLE:   state_nx_s = !sel_s ? ST_IDLE :
                                  (match_s && cnt_r == CNT_CAP) ? ST_CAPTURED : ST_SETTLE;
        ST_CAPTURED: state_nx_s = !sel_s ? ST_IDLE : (match_s ? ST_CAPTURED : ST_SETTLE);
        default:     state_nx_s = ST_IDLE;
      endcase
    end
  end

  // FSM outputs: latch a new candidate, or capture on the last matching sample.
  always_comb begin
    load_s    = 1'b0;
    capture_s = 1'b0;
    if (clear) begin
      load_s    = 1'b0;
      capture_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE:     load_s = sel_s;
        ST_SETTLE: begin
          load_s    = sel_s && !same_s;
          capture_s = match_s && (cnt_r == CNT_CAP);
        end
        ST_CAPTURED: load_s = sel_s && !same_s;
        default: begin
          load_s    = 1'b0;
          capture_s = 1'b0;
        end
      endcase
    end
  end

  // Dwell counter and candidate latch; counter saturates at STABLE_CYCLES.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r     <= 8'd0;
      lat_idx_r <= {IDXW{1'b0}};
      lat_seg_r <= 7'h7F;
      lat_dp_r  <= 1'b1;
    end else if (clear || !sel_s) begin
      cnt_r <= 8'd0;
    end else if (load_s) begin
      cnt_r     <= 8'd1;
      lat_idx_r <= idx_s;
      lat_seg_r <= seg_r;
      lat_dp_r  <= dp_r;
    end else begin
      cnt_r <= (cnt_r == CNT_SAT) ? cnt_r : cnt_r + 8'd1;
    end
  end

  seg7_pattern_decode u_decode (
    .seg_n  (lat_seg_r),
    .hit    (hit_s),
    .nibble (nibble_s)
  );

  // Captured outputs; an unrecognised glyph keeps the old nibble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits_r <= {(4*NDIG){1'b0}};
      valid_r  <= {NDIG{1'b0}};
      perr_r   <= {NDIG{1'b0}};
      dp_out_r <= {NDIG{1'b0}};
      update_r <= 1'b0;
    end else if (clear) begin
      digits_r <= {(4*NDIG){1'b0}};
      valid_r  <= {NDIG{1'b0}};
      perr_r   <= {NDIG{1'b0}};
      dp_out_r <= {NDIG{1'b0}};
      update_r <= 1'b0;
    end else begin
      update_r <= capture_s;
      if (capture_s) begin
        valid_r[lat_idx_r]  <= hit_s;
        perr_r[lat_idx_r]   <= !hit_s;
        dp_out_r[lat_idx_r] <= !lat_dp_r;
        if (hit_s) begin
          digits_r[{lat_idx_r, 2'b00} +: 4] <= nibble_s;
        end else begin
          digits_r <= digits_r;
        end
      end else begin
        digits_r <= digits_r;
      end
    end
  end

  assign digits      = digits_r;
  assign digit_valid = valid_r;
  assign pattern_err = perr_r;
  assign update      = update_r;
`ifdef SEG7_DP_EN
  assign dp          = dp_out_r;
`endif

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Self-checking bench for seg7_scan_decoder: directed scenarios plus random
// scan traffic, checked every cycle against a run-length reference model.
module tb_seg7_scan_decoder;
  import seg7_pkg::*;

  localparam int NDIG   = 4;
  localparam int STABLE = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic [6:0]  seg_n = 7'h7F;
  logic [3:0]  an_n = 4'hF;
  logic [15:0] digits;
  logic [3:0]  digit_valid, pattern_err;
  logic        update;
`ifdef SEG7_DP_EN
  logic        dp_n = 1'b1;
  logic [3:0]  dp;
`endif

  always #5 clk = ~clk;

  seg7_scan_decoder #(.STABLE_CYCLES(STABLE), .NDIG(NDIG)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_n       (seg_n),
    .an_n        (an_n),
`ifdef SEG7_DP_EN
    .dp_n        (dp_n),
    .dp          (dp),
`endif
    .clear       (clear),
    .digits      (digits),
    .digit_valid (digit_valid),
    .pattern_err (pattern_err),
    .update      (update)
  );

  string      pat_str [16] = '{"ABCDEF", "BC", "ABDEG", "ABCDG", "BCFG", "ACDFG",
                               "ACDEFG", "ABC", "ABCDEFG", "ABCDFG", "ABCEFG",
                               "CDEFG", "ADEF", "BCDEG", "ADEFG", "AEFG"};
  logic [6:0] pat_mask [16];

  logic [3:0] m_dig [4];
  logic [3:0] m_val, m_err, m_dp;
  int         run;
  logic [3:0] p_an;
  logic [6:0] p_seg;
  logic       p_dp;
  logic       pend, pend_dpn, exp_upd;
  int         pend_pos;
  logic [6:0] pend_seg;
  int         n_cmp, n_err, upd_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] mask_of(input string s);
    logic [6:0] m = 7'h00;
    for (int i = 0; i < s.len(); i++) m[int'(s[i]) - 65] = 1'b1;
    return m;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_dig[i] = 4'h0;
    m_val = 4'h0; m_err = 4'h0; m_dp = 4'h0;
    run = 0; pend = 1'b0;
  endtask

  task automatic apply_capture();
    logic hit = 1'b0;
    for (int j = 0; j < 16; j++) begin
      if (pat_mask[j] == ~pend_seg) begin
        hit = 1'b1;
        m_dig[pend_pos] = 4'(j);
      end
    end
    m_val[pend_pos] = hit;
    m_err[pend_pos] = !hit;
    m_dp[pend_pos]  = !pend_dpn;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".digits"}, {16'h0, digits}, {16'h0, m_dig[3], m_dig[2], m_dig[1], m_dig[0]});
    chk({tag, ".valid"}, {28'h0, digit_valid}, {28'h0, m_val});
    chk({tag, ".perr"}, {28'h0, pattern_err}, {28'h0, m_err});
`ifdef SEG7_DP_EN
    chk({tag, ".dp"}, {28'h0, dp}, {28'h0, m_dp});
`endif
  endtask

  // One input sample; the model predicts what the following edge shows.
  task automatic step(input logic [3:0] an, input logic [6:0] seg, input logic dpn, input logic clr);
    logic sel, dpe;
    int   pos = 0;
    @(negedge clk);
    an_n = an; seg_n = seg; clear = clr;
`ifdef SEG7_DP_EN
    dp_n = dpn;
    dpe  = dpn;
`else
    dpe  = 1'b1;
`endif
    exp_upd = 1'b0;
    if (clr) begin
      model_reset();
    end else if (pend) begin
      apply_capture();
      exp_upd = 1'b1;
      pend = 1'b0;
    end
    sel = ($countones(~an) == 1);
    for (int i = 0; i < 4; i++) if (!an[i]) pos = i;
    if (!sel) run = 0;
    else if (!clr && run > 0 && an == p_an && seg == p_seg && dpe == p_dp) run++;
    else run = 1;
    p_an = an; p_seg = seg; p_dp = dpe;
    if (run == STABLE) begin
      pend = 1'b1; pend_pos = pos; pend_seg = seg; pend_dpn = dpe;
    end
    @(posedge clk);
    #1;
    if (update) upd_cnt++;
    chk("update", {31'h0, update}, {31'h0, exp_upd});
    check_outputs("step");
  endtask

  task automatic hold(input logic [3:0] an, input logic [6:0] seg, input int n);
    for (int i = 0; i < n; i++) step(an, seg, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    an_n = 4'hF; seg_n = 7'h7F; clear = 1'b0;
`ifdef SEG7_DP_EN
    dp_n = 1'b1;
`endif
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    check_outputs("reset");
    chk("reset.update", {31'h0, update}, 32'h0);
    chk("reset.state", 32'(dut.state_r), 32'(ST_IDLE));
    rst_n = 1'b1;
  endtask

  initial begin
    n_cmp = 0; n_err = 0; upd_cnt = 0;
    for (int j = 0; j < 16; j++) pat_mask[j] = mask_of(pat_str[j]);
    model_reset();
    p_an = 4'hF; p_seg = 7'h7F; p_dp = 1'b1;
    do_reset();

    // Single capture of "3" at anode 0.
    upd_cnt = 0;
    hold(4'b1110, 7'h30, STABLE);
    hold(4'b1111, 7'h7F, 2);
    chk("req033.updates", upd_cnt, 32'd1);
    chk("req033.nibble", {28'h0, digits[3:0]}, 32'h3);
    chk("req033.valid0", {31'h0, digit_valid[0]}, 32'h1);

    // Scan 1,8,3,1 across all four positions.
    hold(4'b1110, 7'h79, STABLE);
    hold(4'b1101, 7'h00, STABLE);
    hold(4'b1011, 7'h30, STABLE);
    hold(4'b0111, 7'h79, STABLE);
    hold(4'b1111, 7'h7F, 1);
    chk("req034.digits", {16'h0, digits}, 32'h1381);
    chk("req034.valid", {28'h0, digit_valid}, 32'hF);

    // Blank glyph is unrecognised and leaves the nibble alone.
    hold(4'b1011, 7'h7F, STABLE);
    hold(4'b1111, 7'h7F, 1);
    chk("req035.perr2", {31'h0, pattern_err[2]}, 32'h1);
    chk("req035.valid2", {31'h0, digit_valid[2]}, 32'h0);
    chk("req035.nib2", {28'h0, digits[11:8]}, 32'h3);

    // Seven matches then a two-anode sample: abandoned.
    upd_cnt = 0;
    hold(4'b1101, 7'h79, STABLE - 1);
    hold(4'b1100, 7'h79, 1);
    hold(4'b1111, 7'h7F, 1);
    chk("req036.updates", upd_cnt, 32'd0);
    chk("req036.state", 32'(dut.state_r), 32'(ST_IDLE));

    // Long dwell captures exactly once.
    upd_cnt = 0;
    hold(4'b1110, 7'h24, 40);
    hold(4'b1111, 7'h7F, 1);
    chk("req037.updates", upd_cnt, 32'd1);

    // Clear on the capture edge wins.
    upd_cnt = 0;
    hold(4'b0111, 7'h00, STABLE);
    step(4'b0111, 7'h00, 1'b1, 1'b1);
    hold(4'b1111, 7'h7F, 1);
    chk("req038.clr_updates", upd_cnt, 32'd0);
    chk("req038.clr_digits", {16'h0, digits}, 32'h0);
    chk("req038.clr_valid", {28'h0, digit_valid}, 32'h0);

    // Reset in the middle of a dwell abandons it.
    upd_cnt = 0;
    hold(4'b1110, 7'h30, 5);
    do_reset();
    hold(4'b1110, 7'h30, 3);
    hold(4'b1111, 7'h7F, 1);
    chk("req038.rst_updates", upd_cnt, 32'd0);

    // Random scan traffic.
    for (int s = 0; s < 80; s++) begin
      logic [3:0] an;
      logic [6:0] seg;
      logic       dpn;
      int         len;
      if ($urandom_range(0, 9) < 8) an = ~(4'b0001 << $urandom_range(0, 3));
      else an = 4'($urandom);
      if ($urandom_range(0, 9) < 7) seg = ~pat_mask[$urandom_range(0, 15)];
      else seg = 7'($urandom);
      dpn = 1'($urandom);
      len = $urandom_range(1, 12);
      for (int k = 0; k < len; k++) step(an, seg, dpn, ($urandom_range(0, 59) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seg7_scan_decoder.md
SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 8, meaning consecutive identical sample cycles required before a capture (legal range 2..255).
REQ-002 SHALL have parameter NDIG, default 4, meaning number of multiplexed digit positions.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 seg_n  input  7  active-low segment drive, bit order {G,F,E,D,C,B,A}; segment lit when its bit is 0.
REQ-006 an_n  input  NDIG  active-low digit-select (anode) drive.
REQ-007 clear  input  1  synchronous clear of all captured state.
REQ-008 digits  output  4*NDIG  recovered hex nibbles; nibble i belongs to anode i.
REQ-009 digit_valid  output  NDIG  nibble i holds a decoded value.
REQ-010 pattern_err  output  NDIG  last capture at position i was an unrecognised pattern.
REQ-011 update  output  1  one-cycle pulse on every capture.

Function
REQ-012 Inputs SHALL be registered once before use; the two-flop synchroniser is not part of this block.
REQ-013 A sample SHALL be "selectable" only when exactly one bit of an_n is 0.
REQ-014 The FSM SHALL have states IDLE, SETTLE and CAPTURED.
REQ-015 IDLE -> SETTLE on a selectable sample; the dwell counter loads 1 and the anode index and seg_n are latched.
REQ-016 In SETTLE, a sample with the same anode index and seg_n SHALL increment the counter.
REQ-017 In SETTLE, a selectable sample that differs SHALL re-latch and reload the counter to 1; a non-selectable sample SHALL return to IDLE.
REQ-018 When the counter reaches STABLE_CYCLES, the FSM SHALL perform the capture and enter CAPTURED.
REQ-019 A capture SHALL become visible on the outputs exactly one cycle after the STABLE_CYCLES-th matching registered sample.
REQ-020 A recognised capture SHALL write digits[i], set digit_valid[i], clear pattern_err[i] and pulse update.
REQ-021 An unrecognised capture SHALL leave digits[i] unchanged, clear digit_valid[i], set pattern_err[i] and pulse update.
REQ-022 CAPTURED SHALL hold and never re-capture while the latched anode and seg_n persist.
REQ-023 From CAPTURED, any change SHALL behave as in SETTLE: a selectable change re-latches and enters SETTLE, a non-selectable sample enters IDLE.
REQ-024 Recognised lit-segment sets:
- 0 ABCDEF; 1 BC; 2 ABDEG; 3 ABCDG; 4 BCFG; 5 ACDFG; 6 ACDEFG; 7 ABC
- 8 ABCDEFG; 9 ABCDFG; A ABCEFG; b CDEFG; C ADEF; d BCDEG; E ADEFG; F AEFG
- All other patterns, including blank, SHALL be treated as unrecognised.
REQ-025 The dwell counter SHALL saturate and never wrap.
REQ-026 clear SHALL take priority over a capture in the same cycle, zero all outputs and force IDLE.

Reset
REQ-027 While rst_n=0: digits=0, digit_valid=0, pattern_err=0, update=0, FSM=IDLE, counter=0 and input registers all-ones (inactive).
REQ-028 Assertion of rst_n mid-dwell SHALL abandon the capture with no update pulse.

Configuration
REQ-029 With SEG7_DP_EN defined: input dp_n (1 bit, active-low) and output dp (NDIG bits) SHALL exist; dp_n joins the stability compare and dp[i] is written on every capture at position i.
REQ-030 Without SEG7_DP_EN: neither port exists and the decimal point is ignored.

Structure
REQ-031 Package seg7_pkg SHALL hold the segment bit-index constants, the FSM state enum and the 16-entry pattern constants.
REQ-032 Sub-module seg7_pattern_decode SHALL be the combinational 7-bit-to-{hit, nibble} lookup, instantiated once.

Verification
REQ-033 an_n=4'b1110, seg_n=7'h30 held for 8 cycles -> one update pulse, digits[3:0]=4'h3, digit_valid[0]=1.
REQ-034 An 8-cycle dwell at each position with 1 (7'h79), 8 (7'h00), 3 (7'h30) and 1 (7'h79) -> digits=16'h1381 and digit_valid=4'hF.
REQ-035 seg_n=7'h7F (blank) at an_n=4'b1011 for 8 cycles -> pattern_err[2]=1, digit_valid[2]=0, digits[11:8] unchanged.
REQ-036 7 matching cycles followed by a change to an_n=4'b1100 -> no update pulse and FSM=IDLE.
REQ-037 A 40-cycle dwell -> exactly one update pulse.
REQ-038 clear asserted on the capture cycle -> all outputs 0 and no update pulse; rst_n pulsed low mid-dwell -> no update pulse.
